// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared operation codes, FSM state type and opcode helpers
//                for the execute-stage ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation codes driven by the ALU controller
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_JAL   = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_XOR   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_BNE   = 4'b1001;
    localparam logic [3:0] OP_BLT   = 4'b1010;
    localparam logic [3:0] OP_BGE   = 4'b1011;
    localparam logic [3:0] OP_SLT   = 4'b1100;
    localparam logic [3:0] OP_RSV_D = 4'b1101;
    localparam logic [3:0] OP_RSV_E = 4'b1110;
    localparam logic [3:0] OP_RSV_F = 4'b1111;

    // Execute-stage control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ops that go through the iterative shifter
    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Conditional branches (BEQ/BNE/BLT/BGE share the 10xx prefix)
    function automatic logic is_branch_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shifter_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_shifter_iter
//  Description : Multi-cycle shifter. Moves at most SHIFT_STEP bit positions
//                per cycle; done is asserted in the cycle whose step brings
//                the remaining count to zero, with result valid alongside.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_shifter_iter
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] value,
    input  logic [4:0]        shamt,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int             CNT_W = 6;
    localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFT_STEP);

    logic [DATA_W-1:0]   r_work;
    logic [CNT_W-1:0]    r_remaining;
    logic [3:0]          r_op;
    logic                r_sign;

    logic [CNT_W-1:0]    w_k;
    logic [2*DATA_W-1:0] w_ext;
    logic [2*DATA_W-1:0] w_right;
    logic [DATA_W-1:0]   w_next;
    logic                w_busy;

    assign w_busy = (r_remaining != '0);
    assign done   = w_busy && (r_remaining <= STEP);
    assign result = w_next;

    // One shift step: k = min(SHIFT_STEP, remaining); SRA fills with the
    // sign of the original operand, captured at start.
    always_comb begin
        w_k     = (r_remaining < STEP) ? r_remaining : STEP;
        w_ext   = (r_op == OP_SRA) ? {{DATA_W{r_sign}}, r_work}
                                   : {{DATA_W{1'b0}}, r_work};
        w_right = w_ext >> w_k;
        if (r_op == OP_SLL) begin
            w_next = r_work << w_k;
        end else begin
            w_next = w_right[DATA_W-1:0];
        end
    end

    // Working value and remaining-count register; clear aborts a shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work      <= '0;
            r_remaining <= '0;
            r_op        <= OP_AND;
            r_sign      <= 1'b0;
        end else if (clear) begin
            r_remaining <= '0;
        end else if (start) begin
            r_work      <= value;
            r_remaining <= {1'b0, shamt};
            r_op        <= op;
            r_sign      <= value[DATA_W-1];
        end else if (w_busy) begin
            r_work      <= w_next;
            r_remaining <= r_remaining - w_k;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Execute-stage ALU with valid/ready handshakes. Logic, add,
//                compare and branch ops finish in one cycle; shifts iterate
//                through alu_shifter_iter. Flush kills any in-flight op.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHIFT_STEP = 4,
    parameter int TAG_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Operation,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ALUResult,
    output logic              branch_taken,
    output logic [TAG_W-1:0]  out_tag
);

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_result;
    logic                r_branch;
    logic [TAG_W-1:0]    r_tag;
    logic [TAG_W-1:0]    r_pend_tag;

    logic                w_accept;
    logic                w_shift_go;
    logic                w_sh_done;
    logic                w_sh_load;
    logic [DATA_W-1:0]   w_sh_result;
    logic [DATA_W-1:0]   w_result;
    logic                w_branch;
    logic [DATA_W-1:0]   w_sum;
    logic                w_lt;
    logic                w_eq;

    assign in_ready   = !flush && ((r_state == ST_IDLE) ||
                                   ((r_state == ST_DONE) && out_ready));
    assign w_accept   = in_valid && in_ready;
    assign w_shift_go = is_shift_op(Operation) && (SrcB[4:0] != 5'd0);
    assign w_sh_load  = (r_state == ST_SHIFT) && w_sh_done && !flush;

    assign out_valid    = (r_state == ST_DONE);
    assign ALUResult    = r_result;
    assign branch_taken = r_branch;
    assign out_tag      = r_tag;

    alu_shifter_iter #(
        .DATA_W     (DATA_W),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (flush),
        .start  (w_accept && w_shift_go),
        .op     (Operation),
        .value  (SrcA),
        .shamt  (SrcB[4:0]),
        .done   (w_sh_done),
        .result (w_sh_result)
    );

    // Single-cycle datapath; a shift by zero simply passes SrcA through
    always_comb begin
        w_sum    = SrcA + SrcB;
        w_lt     = ($signed(SrcA) < $signed(SrcB));
        w_eq     = (SrcA == SrcB);
        w_result = '0;
        w_branch = 1'b0;
        case (Operation)
            OP_AND: w_result = SrcA & SrcB;
            OP_OR:  w_result = SrcA | SrcB;
            OP_ADD: w_result = w_sum;
            OP_XOR: w_result = SrcA ^ SrcB;
            OP_SLL, OP_SRL, OP_SRA: w_result = SrcA;
            OP_SLT: w_result = DATA_W'(w_lt);
            OP_BEQ: begin w_result = DATA_W'(w_eq);  w_branch = w_eq;  end
            OP_BNE: begin w_result = DATA_W'(!w_eq); w_branch = !w_eq; end
            OP_BLT: begin w_result = DATA_W'(w_lt);  w_branch = w_lt;  end
            OP_BGE: begin w_result = DATA_W'(!w_lt); w_branch = !w_lt; end
            OP_JAL: begin w_result = SrcA + DATA_W'(4); w_branch = 1'b1; end
            default: begin w_result = '0; w_branch = 1'b0; end
        endcase
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_next = w_shift_go ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    if (w_sh_done) begin
                        w_state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (w_accept) begin
                        w_state_next = w_shift_go ? ST_SHIFT : ST_DONE;
                    end else if (out_ready) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Result registers: loaded at accept for one-cycle ops, or at the last
    // shift step; a shift's tag waits in r_pend_tag so visible outputs keep
    // their previous values until the new result is actually ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_branch   <= 1'b0;
            r_tag      <= '0;
            r_pend_tag <= '0;
        end else if (w_accept && !w_shift_go) begin
            r_result <= w_result;
            r_branch <= w_branch;
            r_tag    <= in_tag;
        end else if (w_accept) begin
            r_pend_tag <= in_tag;
        end else if (w_sh_load) begin
            r_result <= w_sh_result;
            r_branch <= 1'b0;
            r_tag    <= r_pend_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_stage
//  Description : Self-checking bench for alu_exec_stage with a behavioural
//                reference model for results and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    localparam int DATA_W     = 32;
    localparam int SHIFT_STEP = 4;
    localparam int TAG_W      = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        Operation = 4'd0;
    logic [DATA_W-1:0] SrcA = '0;
    logic [DATA_W-1:0] SrcB = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] ALUResult;
    logic              branch_taken;
    logic [TAG_W-1:0]  out_tag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(
        .DATA_W     (DATA_W),
        .SHIFT_STEP (SHIFT_STEP),
        .TAG_W      (TAG_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .Operation    (Operation),
        .SrcA         (SrcA),
        .SrcB         (SrcB),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .ALUResult    (ALUResult),
        .branch_taken (branch_taken),
        .out_tag      (out_tag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what each opcode means, in plain arithmetic
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic br);
        int s;
        s  = int'(b[4:0]);
        br = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a ^ b;
            4'b0100: r = a << s;
            4'b0101: r = a >> s;
            4'b0111: r = $signed(a) >>> s;
            4'b1100: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin br = (a == b);                   r = {31'd0, br}; end
            4'b1001: begin br = (a != b);                   r = {31'd0, br}; end
            4'b1010: begin br = ($signed(a) < $signed(b));  r = {31'd0, br}; end
            4'b1011: begin br = ($signed(a) >= $signed(b)); r = {31'd0, br}; end
            4'b0011: begin r = a + 32'd4; br = 1'b1; end
            default: r = 32'd0;
        endcase
    endfunction

    // Reference latency from accept to first out_valid cycle
    function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        if ((op == 4'b0100 || op == 4'b0101 || op == 4'b0111) && s > 0)
            return 1 + (s + SHIFT_STEP - 1) / SHIFT_STEP;
        return 1;
    endfunction

    // Issue one op from IDLE with out_ready=1 and collect its result (no checks)
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, output int lat, output logic [31:0] res,
                         output logic br, output logic [4:0] tg, output bit to);
        out_ready = 1'b1;
        Operation = op; SrcA = a; SrcB = b; in_tag = tag; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 64) begin
            tick();
            lat++;
        end
        to  = !out_valid;
        res = ALUResult; br = branch_taken; tg = out_tag;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (ALUResult !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", ALUResult); end
        n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL reset_branch: got %b want 0", branch_taken); end
        n_cmp++; if (out_tag !== 5'd0) begin n_bad++; $display("FAIL reset_tag: got %0d want 0", out_tag); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        Operation = 4'b0010; SrcA = 32'h7FFF_FFFF; SrcB = 32'd1; in_tag = 5'd3; in_valid = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_valid_n1: got %b want 1", out_valid); end
        n_cmp++; if (ALUResult !== 32'h8000_0000) begin n_bad++; $display("FAIL add_result: got %h want 80000000", ALUResult); end
        n_cmp++; if (out_tag !== 5'd3) begin n_bad++; $display("FAIL add_tag: got %0d want 3", out_tag); end
        n_cmp++; if (branch_taken !== 1'b0) begin n_bad++; $display("FAIL add_branch: got %b want 0", branch_taken); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL add_valid_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_sra();
        out_ready = 1'b1;
        Operation = 4'b0111; SrcA = 32'h8000_0000; SrcB = 32'd7; in_tag = 5'd11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 3; c++) begin
            n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL sra_shift_cycle%0d: in_ready=%b out_valid=%b want 0/0", c, in_ready, out_valid); end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sra_valid_n3: got %b want 1", out_valid); end
        n_cmp++; if (ALUResult !== 32'hFF00_0000) begin n_bad++; $display("FAIL sra_result: got %h want ff000000", ALUResult); end
        n_cmp++; if (out_tag !== 5'd11) begin n_bad++; $display("FAIL sra_tag: got %0d want 11", out_tag); end
        tick();
    endtask

    task automatic test_branches();
        logic [3:0]  ops [8] = '{4'b1011, 4'b1010, 4'b1001, 4'b0011, 4'b1000, 4'b1011, 4'b1100, 4'b1101};
        logic [31:0] as  [8] = '{32'd5, 32'hFFFF_FFFF, 32'd9, 32'h100, 32'd42, 32'h8000_0000, 32'hFFFF_FFFE, 32'd77};
        logic [31:0] bs  [8] = '{32'd5, 32'd1, 32'd9, 32'd0, 32'd42, 32'd1, 32'd3, 32'd77};
        logic [31:0] res, er;
        logic        br, eb;
        logic [4:0]  tg;
        int          lat;
        bit          to;
        for (int i = 0; i < 8; i++) begin
            ref_alu(ops[i], as[i], bs[i], er, eb);
            do_op(ops[i], as[i], bs[i], 5'(i + 20), lat, res, br, tg, to);
            n_cmp++; if (to || res !== er || br !== eb || tg !== 5'(i + 20) || lat != 1) begin
                n_bad++; $display("FAIL branch_op%0d op=%b: got res=%h br=%b tag=%0d lat=%0d to=%0b want res=%h br=%b tag=%0d lat=1",
                                  i, ops[i], res, br, tg, lat, to, er, eb, i + 20);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a1, b1, a2, b2;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        out_ready = 1'b0;
        Operation = 4'b0110; SrcA = a1; SrcB = b1; in_tag = 5'd17; in_valid = 1'b1;
        tick();
        Operation = 4'b0000; SrcA = a2; SrcB = b2; in_tag = 5'd18;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (out_valid !== 1'b1 || ALUResult !== (a1 ^ b1) || out_tag !== 5'd17 || in_ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold%0d: got v=%b res=%h tag=%0d rdy=%b want v=1 res=%h tag=17 rdy=0",
                                  c, out_valid, ALUResult, out_tag, in_ready, a1 ^ b1);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || ALUResult !== (a2 & b2) || out_tag !== 5'd18) begin
            n_bad++; $display("FAIL bp_next_result: got v=%b res=%h tag=%0d want v=1 res=%h tag=18", out_valid, ALUResult, out_tag, a2 & b2);
        end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [4];
        logic [31:0] b [4];
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin a[i] = $urandom; b[i] = $urandom; end
        for (int i = 0; i < 4; i++) begin
            Operation = 4'b0010; SrcA = a[i]; SrcB = b[i]; in_tag = 5'(i + 5); in_valid = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || ALUResult !== a[i] + b[i] || out_tag !== 5'(i + 5)) begin
                n_bad++; $display("FAIL b2b_result%0d: got v=%b res=%h tag=%0d want v=1 res=%h tag=%0d",
                                  i, out_valid, ALUResult, out_tag, a[i] + b[i], i + 5);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        logic [31:0] prev_res, res;
        logic        prev_br, br;
        logic [4:0]  prev_tag, tg;
        int          lat, seen;
        bit          to;
        prev_res = ALUResult; prev_br = branch_taken; prev_tag = out_tag;
        out_ready = 1'b1;
        Operation = 4'b0100; SrcA = 32'd1; SrcB = 32'd31; in_tag = 5'd9; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_idle: got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        n_cmp++; if (ALUResult !== prev_res || branch_taken !== prev_br || out_tag !== prev_tag) begin
            n_bad++; $display("FAIL flush_hold: got res=%h br=%b tag=%0d want res=%h br=%b tag=%0d",
                              ALUResult, branch_taken, out_tag, prev_res, prev_br, prev_tag);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            tick();
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_result: got %0d valid cycles want 0", seen); end
        do_op(4'b0010, 32'd2, 32'd2, 5'd4, lat, res, br, tg, to);
        n_cmp++; if (to || res !== 32'd4 || tg !== 5'd4 || lat != 1) begin
            n_bad++; $display("FAIL flush_then_add: got res=%h tag=%0d lat=%0d to=%0b want res=4 tag=4 lat=1", res, tg, lat, to);
        end
        // Flush while a result waits under back-pressure drops it to IDLE
        out_ready = 1'b0;
        Operation = 4'b0010; SrcA = 32'd5; SrcB = 32'd6; in_tag = 5'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || ALUResult !== 32'd11) begin
            n_bad++; $display("FAIL flush_done: got v=%b res=%h want v=0 res=0000000b", out_valid, ALUResult);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        out_ready = 1'b1;
        Operation = 4'b0101; SrcA = $urandom; SrcB = 32'd31; in_tag = 5'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || ALUResult !== 32'd0 || out_tag !== 5'd0 || branch_taken !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_shift: got v=%b res=%h tag=%0d br=%b want all 0", out_valid, ALUResult, out_tag, branch_taken);
        end
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) seen++;
            tick();
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rst_no_result: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, er;
        logic [3:0]  op;
        logic [4:0]  tag, tg;
        logic        br, eb;
        int          lat, el;
        bit          to;
        for (int i = 0; i < 60; i++) begin
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = $urandom;
            tag = 5'($urandom);
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = {1'b1, a[30:0]};
                2: b = {27'd0, 5'(SHIFT_STEP)};
                3: b = b & 32'h1F;
                default: ;
            endcase
            ref_alu(op, a, b, er, eb);
            el = ref_lat(op, b);
            do_op(op, a, b, tag, lat, res, br, tg, to);
            n_cmp++; if (to || res !== er || br !== eb || tg !== tag || lat != el) begin
                n_bad++; $display("FAIL rand%0d op=%b a=%h b=%h: got res=%h br=%b tag=%0d lat=%0d to=%0b want res=%h br=%b tag=%0d lat=%0d",
                                  i, op, a, b, res, br, tg, lat, to, er, eb, tag, el);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sra();
        test_branches();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
